regfile_write_scheduler: RTL

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

---
 rtl/regfile_write_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Merges execute (valE) and memory (valM) write requests into one register-file write port.
// Each requester has a one-entry buffer; same-register conflicts retire E before M.
module regfile_write_scheduler #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic [3:0]        e_dst,
    input  logic [DATA_W-1:0] e_data,
    output logic              e_ready,
    input  logic              m_valid,
    input  logic [3:0]        m_dst,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [14:0]       pending_mask
);

    localparam logic [3:0] NO_DST = 4'hF;

    logic              e_full_p0, m_full_p0;
    logic [3:0]        e_dst_p0, m_dst_p0;
    logic [DATA_W-1:0] e_data_p0, m_data_p0;
    logic              rr_e_last;
    logic              e_grant, m_grant, e_acc, m_acc, conflict;

    function automatic logic [14:0] dst_onehot(input logic [3:0] dst);
        logic [15:0] oh;
        oh = 16'b1 << dst;
        return oh[14:0];
    endfunction

    always_comb begin
        conflict = e_full_p0 && m_full_p0 && (e_dst_p0 != m_dst_p0);
        // Equal destinations always favour E so the valM value is the one left in the register.
        e_grant  = e_full_p0 && (!m_full_p0 || (e_dst_p0 == m_dst_p0) || !rr_e_last);
        m_grant  = m_full_p0 && !e_grant;
        e_ready  = rst_n && (!e_full_p0 || e_grant);
        m_ready  = rst_n && (!m_full_p0 || m_grant);
        e_acc    = e_valid && e_ready && (e_dst != NO_DST);
        m_acc    = m_valid && m_ready && (m_dst != NO_DST);
    end

    always_comb begin
        pending_mask = 15'd0;
        if (e_full_p0) pending_mask = pending_mask | dst_onehot(e_dst_p0);
        if (m_full_p0) pending_mask = pending_mask | dst_onehot(m_dst_p0);
        if (wr_en)     pending_mask = pending_mask | dst_onehot(wr_addr);
    end

    // Stage p0: request buffers and arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_full_p0 <= 1'b0;
            m_full_p0 <= 1'b0;
            rr_e_last <= 1'b1;
        end else begin
            if (e_acc)        e_full_p0 <= 1'b1;
            else if (e_grant) e_full_p0 <= 1'b0;
            if (m_acc)        m_full_p0 <= 1'b1;
            else if (m_grant) m_full_p0 <= 1'b0;
            if (conflict)     rr_e_last <= e_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (e_acc) begin
            e_dst_p0  <= e_dst;
            e_data_p0 <= e_data;
        end
        if (m_acc) begin
            m_dst_p0  <= m_dst;
            m_data_p0 <= m_data;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= NO_DST;
            wr_data <= '0;
        end else begin
            wr_en <= e_grant || m_grant;
            if (e_grant) begin
                wr_addr <= e_dst_p0;
                wr_data <= e_data_p0;
            end else if (m_grant) begin
                wr_addr <= m_dst_p0;
                wr_data <= m_data_p0;
            end
        end
    end

endmodule
